intc_prio: RTL and testbench

- Parametrised successor to the 4-source ISR-table interrupt controller.
- Supports NUM_SRC sources, each with a memory-mapped ISR address register.
- Adds a per-source enable mask, latched pending bits with write-1-to-clear, fixed priority (lowest index wins), and an IRQ/IACK/EOI state machine that blocks re-entry until software ends service.
- Sits on the CPU data bus in the 0x0002xxxx window and drives IRQ/isr_addr to the core.

---
 rtl/intc_pkg.sv | 17 +
 rtl/intc_prio_if.sv | 20 ++
 rtl/intc_prio_enc.sv | 20 ++
 rtl/intc_prio.sv | 145 ++++++++++++++
 tb/tb_intc_prio.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/intc_pkg.sv
// Shared definitions for the priority interrupt controller: FSM encoding
// and the register offsets inside the 256-byte register window.
package intc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_e;

    localparam logic [7:0] OFS_TABLE   = 8'h00;
    localparam logic [7:0] OFS_ENABLE  = 8'h80;
    localparam logic [7:0] OFS_PENDING = 8'h84;
    localparam logic [7:0] OFS_STATUS  = 8'h88;
    localparam logic [7:0] OFS_EOI     = 8'h8C;

endpackage

// File: rtl/intc_prio_if.sv
// CPU data-bus port of the interrupt controller. The CPU side drives
// address/strobe/data, the controller returns combinational read data.
interface intc_prio_if #(
    parameter int DATA_W = 32
);
    logic [31:0]       input_addr;
    logic              write_enable;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;

    modport master (
        output input_addr, write_enable, write_data,
        input  read_data
    );

    modport slave (
        input  input_addr, write_enable, write_data,
        output read_data
    );
endinterface

// File: rtl/intc_prio_enc.sv
// Lowest-index-wins priority encoder over the eligible request vector.
module prio_enc #(
    parameter int NUM_SRC = 8,
    parameter int ID_W    = 4
) (
    input  logic [NUM_SRC-1:0] eligible,
    output logic [ID_W-1:0]    idx,
    output logic               valid
);

    // Scan from the top down so the lowest set index is the last to assign.
    always_comb begin
        idx   = '0;
        valid = |eligible;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) idx = ID_W'(i);
        end
    end

endmodule

// File: rtl/intc_prio.sv
// Priority interrupt controller: per-source ISR table, enable mask,
// edge-latched pending bits (write-1-to-clear), fixed lowest-index
// priority and an IDLE/REQ/SERVICE handshake with the core.
module intc_prio
    import intc_pkg::*;
#(
    parameter int          NUM_SRC   = 8,
    parameter int          DATA_W    = 32,
    parameter logic [31:0] BASE_ADDR = 32'h0002_0000,
    parameter int          ID_W      = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] done,
    input  logic               IACK,
    intc_prio_if.slave         bus,
    output logic               IRQ,
    output logic [DATA_W-1:0]  isr_addr,
    output logic [ID_W-1:0]    active_id,
    output logic               error
);

    state_e                          state, state_nxt;
    logic [NUM_SRC-1:0][DATA_W-1:0]  isr_tab;
    logic [NUM_SRC-1:0]              enable, pending, done_q;
    logic [NUM_SRC-1:0]              rise, eligible, w1c_mask, ack_clear;
    logic [ID_W-1:0]                 win_id;
    logic                            win_vld;
    logic [DATA_W-1:0]               win_addr;
    logic [7:0]                      ofs;
    logic                            in_win, wr, tab_hit, mapped, eoi_wr;
    logic                            err_set;
    logic                            unused_addr_bits;

    // Bits 15:8 alias inside the window; only the low byte selects a register.
    assign unused_addr_bits = ^bus.input_addr[15:8];

    assign ofs     = bus.input_addr[7:0];
    assign in_win  = (bus.input_addr[31:16] == BASE_ADDR[31:16]);
    assign wr      = bus.write_enable && in_win;
    assign tab_hit = (ofs < 8'(4 * NUM_SRC)) && (ofs[1:0] == 2'b00);
    assign mapped  = tab_hit || ofs == OFS_ENABLE || ofs == OFS_PENDING ||
                     ofs == OFS_STATUS || ofs == OFS_EOI;
    assign eoi_wr  = wr && ofs == OFS_EOI;

    assign rise     = done & ~done_q;
    assign eligible = pending & enable;
    assign w1c_mask = (wr && ofs == OFS_PENDING) ? bus.write_data[NUM_SRC-1:0] : '0;
    assign IRQ      = (state == REQ);

    prio_enc #(.NUM_SRC(NUM_SRC), .ID_W(ID_W)) u_enc (
        .eligible (eligible),
        .idx      (win_id),
        .valid    (win_vld)
    );

    // Table lookup for the winner and one-hot clear of the acknowledged source.
    always_comb begin
        win_addr  = '0;
        ack_clear = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (win_id == ID_W'(i)) win_addr = isr_tab[i];
            if (state == REQ && IACK && active_id == ID_W'(i)) ack_clear[i] = 1'b1;
        end
    end

    // Combinational read mux; anything outside the window or unmapped reads 0.
    always_comb begin
        bus.read_data = '0;
        if (in_win) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (tab_hit && ofs == 8'(OFS_TABLE + 8'(4 * i))) bus.read_data = isr_tab[i];
            end
            case (ofs)
                OFS_ENABLE:  bus.read_data = DATA_W'(enable);
                OFS_PENDING: bus.read_data = DATA_W'(pending);
                OFS_STATUS:  bus.read_data = DATA_W'({state, active_id});
                default:     ;
            endcase
        end
    end

    // Software-visible configuration: ISR table and enable mask.
    always_ff @(posedge clk) begin
        if (rst) begin
            isr_tab <= '0;
            enable  <= '0;
        end else if (wr) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (tab_hit && ofs == 8'(OFS_TABLE + 8'(4 * i))) isr_tab[i] <= bus.write_data;
            end
            if (ofs == OFS_ENABLE) enable <= bus.write_data[NUM_SRC-1:0];
        end
    end

    // Edge capture and pending bits; a new rise beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_q  <= '0;
            pending <= '0;
        end else begin
            done_q  <= done;
            pending <= (pending & ~w1c_mask & ~ack_clear) | rise;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state: grant only from IDLE, IACK ends the request, EOI ends service.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_vld) state_nxt = REQ;
            REQ:     if (IACK)    state_nxt = SERVICE;
            SERVICE: if (eoi_wr)  state_nxt = IDLE;
            default:              state_nxt = IDLE;
        endcase
    end

    // Freeze the granted source and its vector at the grant edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            active_id <= '0;
            isr_addr  <= '0;
        end else if (state == IDLE && win_vld) begin
            active_id <= win_id;
            isr_addr  <= win_addr;
        end
    end

    assign err_set = (IACK && state != REQ) ||
                     (eoi_wr && state != SERVICE) ||
                     (wr && !mapped);

    // Sticky protocol/decode error, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst)          error <= 1'b0;
        else if (err_set) error <= 1'b1;
    end

endmodule

// File: tb/tb_intc_prio.sv
// Directed bench for intc_prio with hand-computed expectations.
module tb_intc_prio;
    import intc_pkg::*;

    localparam logic [31:0] BASE = 32'h0002_0000;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] done;
    logic       IACK;
    logic       IRQ;
    logic [31:0] isr_addr;
    logic [3:0] active_id;
    logic       error;
    logic [31:0] rdv;
    int         n_chk = 0;
    int         n_err = 0;

    intc_prio_if #(.DATA_W(32)) bus ();

    intc_prio dut (
        .clk       (clk),
        .rst       (rst),
        .done      (done),
        .IACK      (IACK),
        .bus       (bus),
        .IRQ       (IRQ),
        .isr_addr  (isr_addr),
        .active_id (active_id),
        .error     (error)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, exp finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.input_addr   = a;
        bus.write_data   = d;
        bus.write_enable = 1'b1;
        cyc();
        bus.write_enable = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        bus.input_addr = a;
        #1;
        d = bus.read_data;
    endtask

    task automatic ack();
        IACK = 1'b1;
        cyc();
        IACK = 1'b0;
    endtask

    task automatic do_rst();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; done = '0; IACK = 1'b0;
        bus.input_addr = '0; bus.write_enable = 1'b0; bus.write_data = '0;
        cyc(); cyc();
        rst = 1'b0;
        chk("rst_irq", 32'(IRQ), 0);
        chk("rst_isr", isr_addr, 0);
        chk("rst_id", 32'(active_id), 0);
        chk("rst_err", 32'(error), 0);
        rd(BASE + 32'h80, rdv); chk("rst_en", rdv, 0);

        // Program table and enable, read back
        wr(BASE + 32'h00, 32'h100);
        wr(BASE + 32'h04, 32'h200);
        wr(BASE + 32'h80, 32'h03);
        rd(BASE + 32'h00, rdv); chk("tab0", rdv, 32'h100);
        rd(BASE + 32'h04, rdv); chk("tab1", rdv, 32'h200);
        rd(BASE + 32'h80, rdv); chk("en", rdv, 32'h03);
        rd(BASE + 32'h90, rdv); chk("unmapped_rd", rdv, 0);
        rd(32'h0003_0080, rdv); chk("outwin_rd", rdv, 0);
        wr(32'h0003_0080, 32'hFF);
        rd(BASE + 32'h80, rdv); chk("outwin_wr", rdv, 32'h03);
        chk("outwin_noerr", 32'(error), 0);

        // Single source: done[1]
        done = 8'h02;
        cyc();
        chk("s1_irq_lat", 32'(IRQ), 0);
        rd(BASE + 32'h84, rdv); chk("s1_pend", rdv, 32'h02);
        cyc();
        done = '0;
        chk("s1_irq", 32'(IRQ), 1);
        chk("s1_isr", isr_addr, 32'h200);
        chk("s1_id", 32'(active_id), 1);
        rd(BASE + 32'h88, rdv); chk("s1_stat_req", rdv, 32'h11);
        ack();
        chk("s1_irq_ack", 32'(IRQ), 0);
        rd(BASE + 32'h84, rdv); chk("s1_pend_ack", rdv, 0);
        rd(BASE + 32'h88, rdv); chk("s1_stat_svc", rdv, 32'h21);
        wr(BASE + 32'h8C, 0);
        rd(BASE + 32'h88, rdv); chk("s1_stat_idle", rdv, 32'h01);

        // Simultaneous rises: lowest index first, then the other after EOI
        done = 8'h03;
        cyc(); cyc();
        done = '0;
        chk("s2_irq", 32'(IRQ), 1);
        chk("s2_isr", isr_addr, 32'h100);
        chk("s2_id", 32'(active_id), 0);
        ack();
        rd(BASE + 32'h84, rdv); chk("s2_pend", rdv, 32'h02);
        wr(BASE + 32'h8C, 0);
        chk("s2_irq_eoi", 32'(IRQ), 0);
        cyc();
        chk("s2_irq2", 32'(IRQ), 1);
        chk("s2_isr2", isr_addr, 32'h200);
        ack();
        wr(BASE + 32'h8C, 0);
        chk("s2_noerr", 32'(error), 0);

        // Masked source latches pending, serviced once enabled
        wr(BASE + 32'h80, 32'h00);
        done = 8'h04;
        cyc(); cyc(); cyc();
        done = '0;
        chk("s3_masked", 32'(IRQ), 0);
        rd(BASE + 32'h84, rdv); chk("s3_pend", rdv, 32'h04);
        wr(BASE + 32'h80, 32'h04);
        chk("s3_irq_lat", 32'(IRQ), 0);
        cyc();
        chk("s3_irq", 32'(IRQ), 1);
        chk("s3_id", 32'(active_id), 2);
        // Same-cycle rise and W1C: set wins
        done = 8'h04;
        wr(BASE + 32'h84, 32'h04);
        rd(BASE + 32'h84, rdv); chk("s3_set_wins", rdv, 32'h04);
        // Plain W1C with done held high: clears, no retraction
        wr(BASE + 32'h84, 32'h04);
        rd(BASE + 32'h84, rdv); chk("s3_w1c", rdv, 0);
        chk("s3_no_retract", 32'(IRQ), 1);
        // Table rewrite in REQ does not disturb isr_addr
        wr(BASE + 32'h08, 32'h300);
        chk("s4_isr_frozen", isr_addr, 0);
        for (int i = 0; i < 10; i++) cyc();
        rd(BASE + 32'h84, rdv); chk("s4_level_once", rdv, 0);
        ack();
        wr(BASE + 32'h8C, 0);
        cyc();
        chk("s4_idle", 32'(IRQ), 0);
        done = '0;
        cyc();
        done = 8'h04;
        cyc(); cyc();
        done = '0;
        chk("s4_new_isr", isr_addr, 32'h300);
        ack();
        wr(BASE + 32'h8C, 0);
        chk("s4_noerr", 32'(error), 0);

        // Errors: IACK in IDLE
        ack();
        chk("e_iack", 32'(error), 1);
        cyc();
        chk("e_sticky", 32'(error), 1);
        do_rst();
        chk("e_rst1", 32'(error), 0);
        // EOI in REQ is ignored and flags an error
        wr(BASE + 32'h80, 32'h01);
        done = 8'h01;
        cyc(); cyc();
        done = '0;
        wr(BASE + 32'h8C, 0);
        chk("e_eoi", 32'(error), 1);
        chk("e_eoi_ignored", 32'(IRQ), 1);
        do_rst();
        chk("e_rst2", 32'(error), 0);
        // Unmapped write inside the window
        wr(BASE + 32'h90, 32'h1);
        chk("e_unmapped", 32'(error), 1);
        cyc(); cyc();
        chk("e_unmapped_sticky", 32'(error), 1);
        do_rst();
        chk("e_rst3", 32'(error), 0);

        // Reset in SERVICE with another bit pending
        wr(BASE + 32'h00, 32'h100);
        wr(BASE + 32'h80, 32'h03);
        done = 8'h01;
        cyc(); cyc();
        done = '0;
        ack();
        done = 8'h02;
        cyc();
        done = '0;
        rd(BASE + 32'h84, rdv); chk("r_pend_pre", rdv, 32'h02);
        rd(BASE + 32'h88, rdv); chk("r_stat_pre", rdv, 32'h20);
        rst = 1'b1;
        cyc();
        chk("r_irq", 32'(IRQ), 0);
        rd(BASE + 32'h84, rdv); chk("r_pend", rdv, 0);
        rd(BASE + 32'h88, rdv); chk("r_stat", rdv, 0);
        rd(BASE + 32'h00, rdv); chk("r_tab", rdv, 0);
        rd(BASE + 32'h80, rdv); chk("r_en", rdv, 0);
        rst = 1'b0;
        cyc();
        chk("r_idle", 32'(IRQ), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
